// File: rtl/sample_msg_arbiter_pkg.sv
// Shared stream definitions for the sample/message arbiter and splitter.
// Holds the message length width and header-field helpers.
`ifndef MSG_LENGTH_WIDTH
`define MSG_LENGTH_WIDTH 15
`endif

package sample_msg_arbiter_pkg;

  localparam int MSG_LEN_W = `MSG_LENGTH_WIDTH;

  typedef enum logic {
    OUT_IDLE,
    OUT_MSG
  } out_state_t;

  // Header flag is the word MSB.
  function automatic int flag_bit(input int width);
    return width - 1;
  endfunction

  // Length field sits directly below the flag bit.
  function automatic int len_lsb(input int width);
    return width - 1 - MSG_LEN_W;
  endfunction

endpackage

// File: rtl/sample_msg_arbiter_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports: clk, rst_n, wr_en/din in; rd_en in; dout, full, empty out.
module sample_msg_arbiter_sync_fifo #(
  parameter int WIDTH     = 32,
  parameter int LOG_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << LOG_DEPTH;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [LOG_DEPTH-1:0] wr_ptr;
  logic [LOG_DEPTH-1:0] rd_ptr;
  logic [LOG_DEPTH:0]   count;
  logic                 do_wr;
  logic                 do_rd;

  assign full  = (count == (LOG_DEPTH+1)'(DEPTH));
  assign empty = (count == '0);
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + LOG_DEPTH'(1);
      if (do_rd) rd_ptr <= rd_ptr + LOG_DEPTH'(1);
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + (LOG_DEPTH+1)'(1);
        2'b01:   count <= count - (LOG_DEPTH+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sample_msg_arbiter.sv
// Merges samples and complete messages onto one stream; messages never
// interleave with samples. Ports: clk, rst_n; in_samples(_nd),
// in_msg(_nd) in; out_data, out_nd, error out.
// Macro SAMPLE_MSG_ARB_CHECK_EN: drop and flag samples with MSB set.
module sample_msg_arbiter
  import sample_msg_arbiter_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int SAMPLE_BUF_LOG = 4,
  parameter int MSG_BUF_LOG    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_samples,
  input  logic             in_samples_nd,
  input  logic [WIDTH-1:0] in_msg,
  input  logic             in_msg_nd,
  output logic [WIDTH-1:0] out_data,
  output logic             out_nd,
  output logic             error
);

  localparam int FLAG      = flag_bit(WIDTH);
  localparam int LSB       = len_lsb(WIDTH);
  localparam int CNT_W     = MSG_BUF_LOG + 1;
  localparam int MSG_DEPTH = 1 << MSG_BUF_LOG;

  logic [WIDTH-1:0]     s_dout, m_dout;
  logic                 s_full, s_empty, s_wr, s_rd, s_bad, s_err;
  logic                 m_full, m_empty, m_wr, m_rd;
  logic                 in_busy, discarding, trk_err, msg_done;
  logic [MSG_LEN_W-1:0] rem_in, disc_cnt, rem_out;
  logic [MSG_LEN_W-1:0] hdr_len, out_len;
  logic                 is_hdr, oversize, cnt_dec;
  logic [CNT_W-1:0]     cnt;
  out_state_t           state;

  sample_msg_arbiter_sync_fifo #(
    .WIDTH(WIDTH), .LOG_DEPTH(SAMPLE_BUF_LOG)
  ) u_sample_fifo (
    .clk(clk), .rst_n(rst_n),
    .wr_en(s_wr), .rd_en(s_rd), .din(in_samples),
    .dout(s_dout), .full(s_full), .empty(s_empty)
  );

  sample_msg_arbiter_sync_fifo #(
    .WIDTH(WIDTH), .LOG_DEPTH(MSG_BUF_LOG)
  ) u_msg_fifo (
    .clk(clk), .rst_n(rst_n),
    .wr_en(m_wr), .rd_en(m_rd), .din(in_msg),
    .dout(m_dout), .full(m_full), .empty(m_empty)
  );

`ifdef SAMPLE_MSG_ARB_CHECK_EN
  assign s_bad = in_samples_nd && in_samples[FLAG];
`else
  assign s_bad = 1'b0;
`endif
  assign s_wr  = in_samples_nd && !s_bad;
  assign s_err = s_bad || (s_wr && s_full);

  assign is_hdr   = in_msg[FLAG];
  assign hdr_len  = in_msg[LSB +: MSG_LEN_W];
  assign oversize = int'(hdr_len) >= MSG_DEPTH;
  assign out_len  = m_dout[LSB +: MSG_LEN_W];

  // A body word dropped on a full FIFO still counts toward the
  // message, so framing stays aligned with the sender.
  always_comb begin
    m_wr     = 1'b0;
    trk_err  = 1'b0;
    msg_done = 1'b0;
    if (in_msg_nd && !discarding) begin
      if (is_hdr) begin
        if (in_busy || oversize || m_full) begin
          trk_err = 1'b1;
        end else begin
          m_wr     = 1'b1;
          msg_done = (hdr_len == '0);
        end
      end else if (!in_busy) begin
        trk_err = 1'b1;
      end else begin
        m_wr     = !m_full;
        trk_err  = m_full;
        msg_done = (rem_in == MSG_LEN_W'(1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_busy    <= 1'b0;
      rem_in     <= '0;
      discarding <= 1'b0;
      disc_cnt   <= '0;
    end else if (in_msg_nd) begin
      if (discarding) begin
        disc_cnt <= disc_cnt - MSG_LEN_W'(1);
        if (disc_cnt == MSG_LEN_W'(1)) discarding <= 1'b0;
      end else if (is_hdr) begin
        if (!in_busy && oversize) begin
          discarding <= 1'b1;
          disc_cnt   <= hdr_len;
        end else if (m_wr && hdr_len != '0) begin
          in_busy <= 1'b1;
          rem_in  <= hdr_len;
        end
      end else if (in_busy) begin
        rem_in <= rem_in - MSG_LEN_W'(1);
        if (rem_in == MSG_LEN_W'(1)) in_busy <= 1'b0;
      end
    end
  end

  // Pops are gated on !empty so a corrupted stream never underflows.
  always_comb begin
    s_rd    = 1'b0;
    m_rd    = 1'b0;
    cnt_dec = 1'b0;
    unique case (state)
      OUT_IDLE: begin
        if (cnt != '0 && !m_empty) begin
          m_rd    = 1'b1;
          cnt_dec = (out_len == '0);
        end else if (!s_empty) begin
          s_rd = 1'b1;
        end
      end
      OUT_MSG: begin
        if (!m_empty) begin
          m_rd    = 1'b1;
          cnt_dec = (rem_out == MSG_LEN_W'(1)) && cnt != '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= OUT_IDLE;
      rem_out  <= '0;
      cnt      <= '0;
      out_nd   <= 1'b0;
      out_data <= '0;
      error    <= 1'b0;
    end else begin
      out_nd <= s_rd || m_rd;
      if (m_rd)      out_data <= m_dout;
      else if (s_rd) out_data <= s_dout;
      unique case (state)
        OUT_IDLE: begin
          if (m_rd && out_len != '0) begin
            state   <= OUT_MSG;
            rem_out <= out_len;
          end
        end
        OUT_MSG: begin
          if (m_rd) begin
            rem_out <= rem_out - MSG_LEN_W'(1);
            if (rem_out == MSG_LEN_W'(1)) state <= OUT_IDLE;
          end
        end
        default: state <= OUT_IDLE;
      endcase
      unique case ({msg_done, cnt_dec})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: ;
      endcase
      error <= error || s_err || trk_err;
    end
  end

endmodule

// File: tb/tb_sample_msg_arbiter.sv
// Randomized and directed bench for sample_msg_arbiter against a
// queue-based stream model.
module tb_sample_msg_arbiter;

`ifdef SAMPLE_MSG_ARB_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] in_samples = '0;
  logic        in_samples_nd = 1'b0;
  logic [31:0] in_msg = '0;
  logic        in_msg_nd = 1'b0;
  logic [31:0] out_data;
  logic        out_nd;
  logic        error;

  sample_msg_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .in_samples(in_samples), .in_samples_nd(in_samples_nd),
    .in_msg(in_msg), .in_msg_nd(in_msg_nd),
    .out_data(out_data), .out_nd(out_nd), .error(error)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: buffered words, lengths of finished messages.
  logic [31:0] sq[$];
  logic [31:0] mq[$];
  int          done_lens[$];
  int          cur_left, rem, cur_len, disc;
  bit          busy;
  logic        exp_nd;
  logic [31:0] exp_data;
  logic        exp_err;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    sq.delete();
    mq.delete();
    done_lens.delete();
    cur_left = 0; rem = 0; cur_len = 0; disc = 0; busy = 0;
    exp_nd = 0; exp_data = '0; exp_err = 0;
  endfunction

  function automatic logic [31:0] hdr(input int len);
    return {1'b1, 15'(len), 16'h0};
  endfunction

  function automatic void model_step(input logic snd, input logic [31:0] s,
                                     input logic mnd, input logic [31:0] m);
    bit sfull = sq.size() >= 16;
    bit mfull = mq.size() >= 32;
    int len;
    exp_nd = 0;
    if (cur_left > 0) begin
      exp_nd = 1; exp_data = mq.pop_front(); cur_left--;
    end else if (done_lens.size() > 0) begin
      exp_nd = 1; exp_data = mq.pop_front(); cur_left = done_lens.pop_front();
    end else if (sq.size() > 0) begin
      exp_nd = 1; exp_data = sq.pop_front();
    end
    if (snd) begin
      if (CHECK_EN && s[31]) exp_err = 1;
      else if (sfull) exp_err = 1;
      else sq.push_back(s);
    end
    if (mnd) begin
      if (disc > 0) begin
        disc--;
      end else if (m[31]) begin
        len = int'(m[30:16]);
        if (busy) exp_err = 1;
        else if (len + 1 > 32) begin exp_err = 1; disc = len; end
        else if (mfull) exp_err = 1;
        else begin
          mq.push_back(m);
          if (len == 0) done_lens.push_back(0);
          else begin busy = 1; rem = len; cur_len = len; end
        end
      end else if (!busy) begin
        exp_err = 1;
      end else begin
        if (mfull) exp_err = 1;
        else mq.push_back(m);
        rem--;
        if (rem == 0) begin busy = 0; done_lens.push_back(cur_len); end
      end
    end
  endfunction

  task automatic step(input logic snd, input logic [31:0] s,
                      input logic mnd, input logic [31:0] m);
    in_samples_nd = snd; in_samples = s;
    in_msg_nd = mnd; in_msg = m;
    @(posedge clk);
    model_step(snd, s, mnd, m);
    @(negedge clk);
    chk("out_nd", out_nd, exp_nd);
    if (exp_nd) chk("out_data", out_data, exp_data);
    chk("error", error, exp_err);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, '0);
  endtask

  task automatic pulse_reset();
    in_samples_nd = 0; in_msg_nd = 0;
    rst_n = 0;
    model_reset();
    #1;
    chk("rst_nd", out_nd, exp_nd);
    chk("rst_data", out_data, exp_data);
    chk("rst_err", error, exp_err);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  logic [31:0] t2[3];
  logic [31:0] pend[$];
  logic        snd, mnd;
  logic [31:0] sv, mv;
  int          l;

  initial begin
    model_reset();
    @(negedge clk);
    pulse_reset();

    for (int i = 1; i <= 5; i++) step(1, 32'(i), 0, '0);
    idle(8);

    t2[0] = 32'h8002_0000; t2[1] = 32'h11; t2[2] = 32'h22;
    for (int i = 0; i < 12; i++)
      step(1, 32'h100 + 32'(i), (i >= 2 && i <= 4),
           (i >= 2 && i <= 4) ? t2[i-2] : 32'h0);
    idle(10);

    step(0, '0, 1, 32'h8000_0000);
    idle(5);

    step(1, 32'h8000_0001, 0, '0);
    idle(4);

    for (int c = 0; c < 500; c++) begin
      if (pend.size() == 0 && $urandom_range(9) == 0) begin
        l = int'($urandom_range(6));
        pend.push_back(hdr(l));
        for (int k = 0; k < l; k++) pend.push_back($urandom & 32'h7fff_ffff);
      end
      snd = ($urandom_range(9) < 3);
      sv  = $urandom & 32'h7fff_ffff;
      mnd = (pend.size() > 0) && ($urandom_range(9) < 7);
      mv  = mnd ? pend.pop_front() : 32'h0;
      step(snd, sv, mnd, mv);
    end
    while (pend.size() > 0) step(0, '0, 1, pend.pop_front());
    idle(40);

    step(0, '0, 1, hdr(20));
    for (int i = 0; i < 20; i++) step(0, '0, 1, 32'h300 + 32'(i));
    for (int i = 0; i < 17; i++) step(1, 32'h200 + 32'(i), 0, '0);
    idle(3);
    pulse_reset();

    step(1, 32'h55, 0, '0);
    idle(4);

    step(0, '0, 1, hdr(40));
    for (int i = 0; i < 40; i++) step(0, '0, 1, 32'(i + 1));
    idle(5);
    step(0, '0, 1, hdr(1));
    step(0, '0, 1, 32'h77);
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
